// File: rtl/cache_refill_ctrl_if.sv
// Memory read port for I-cache line refill.
// Controller drives req/addr, memory returns ack/rvalid/rdata.
interface cache_refill_ctrl_if #(
  parameter int LINE_W = 256
);
  logic              mem_req;
  logic [31:0]       mem_addr;
  logic              mem_ack;
  logic              mem_rvalid;
  logic [LINE_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_addr,
    input  mem_ack, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_addr,
    output mem_ack, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/cache_refill_ctrl.sv
// Miss handling, LRU victim choice, line refill and flush
// sequencing for the 2-way set-associative instruction cache.
module cache_refill_ctrl #(
  parameter int LINE_W = 256,
  parameter int TAG_W  = 24,
  parameter int IDX_W  = 3,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       pcOut,
  input  logic              fetch_valid,
  input  logic              match_set0,
  input  logic              match_set1,
  input  logic              valid_set0,
  input  logic              valid_set1,
  input  logic              flush,
  cache_refill_ctrl_if.master mem,
  output logic              hit,
  output logic              stall,
  output logic              regWrite_set0,
  output logic              regWrite_set1,
  output logic [IDX_W-1:0]  wr_index,
  output logic              inp_viv,
  output logic [TAG_W-1:0]  in_tag,
  output logic [LINE_W-1:0] inputData,
  output logic [CNT_W-1:0]  miss_count
);

  localparam int LINES = 2 ** IDX_W;
  localparam int IDX_LO = 5;
  localparam int TAG_LO = IDX_LO + IDX_W;

  typedef enum logic [2:0] {
    IDLE, REQ, WAIT, FILL, FLUSH
  } state_t;

  state_t            state, nxt;
  logic [LINES-1:0]  lru;
  logic              victim;
  logic              hit0, hit_any;
  logic              miss;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  last_idx;
  logic [31:0]       addr_q;

  assign idx      = pcOut[TAG_LO-1:IDX_LO];
  assign last_idx = '1;
  assign hit0     = match_set0 & valid_set0;
  assign hit_any  = hit0 | (match_set1 & valid_set1);
  assign mem.mem_addr = addr_q;

  always_comb begin
    nxt           = state;
    hit           = 1'b0;
    stall         = 1'b0;
    miss          = 1'b0;
    mem.mem_req   = 1'b0;
    regWrite_set0 = 1'b0;
    regWrite_set1 = 1'b0;
    inp_viv       = 1'b0;
    unique case (state)
      IDLE: begin
        hit   = fetch_valid & ~flush & hit_any;
        stall = fetch_valid & ~hit;
        miss  = fetch_valid & ~flush & ~hit_any;
        if (flush)     nxt = FLUSH;
        else if (miss) nxt = REQ;
      end
      REQ: begin
        stall       = 1'b1;
        mem.mem_req = 1'b1;
        if (mem.mem_ack)
          nxt = mem.mem_rvalid ? FILL : WAIT;
      end
      WAIT: begin
        stall = 1'b1;
        if (mem.mem_rvalid) nxt = FILL;
      end
      FILL: begin
        stall         = 1'b1;
        regWrite_set0 = ~victim;
        regWrite_set1 = victim;
        inp_viv       = 1'b1;
        nxt           = IDLE;
      end
      FLUSH: begin
        stall         = 1'b1;
        regWrite_set0 = 1'b1;
        regWrite_set1 = 1'b1;
        if (wr_index == last_idx) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      lru        <= '0;
      victim     <= 1'b0;
      addr_q     <= '0;
      in_tag     <= '0;
      wr_index   <= '0;
      inputData  <= '0;
      miss_count <= '0;
    end else begin
      state <= nxt;
      unique case (state)
        IDLE: begin
          if (flush) begin
            wr_index <= '0;
            in_tag   <= '0;
            lru      <= '0;
          end else if (hit) begin
            lru[idx] <= hit0;
          end else if (miss) begin
            addr_q   <= {pcOut[31:IDX_LO], 5'b0};
            in_tag   <= pcOut[31:TAG_LO];
            wr_index <= idx;
            // fill an empty way first, else LRU picks
            victim   <= !valid_set0 ? 1'b0 :
                        !valid_set1 ? 1'b1 : lru[idx];
            if (miss_count != '1)
              miss_count <= miss_count + 1'b1;
          end
        end
        REQ: begin
          if (mem.mem_ack && mem.mem_rvalid)
            inputData <= mem.mem_rdata;
        end
        WAIT: begin
          if (mem.mem_rvalid)
            inputData <= mem.mem_rdata;
        end
        FILL: lru[wr_index] <= ~victim;
        FLUSH: begin
          lru <= '0;
          if (wr_index != last_idx)
            wr_index <= wr_index + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
